pc_npc_fetch_unit: RTL and testbench
====================================

Name: pc_npc_fetch_unit

Overview:
Parametrised successor to the fixed 32-bit PC/nPC register pair and PC adder/mux. Holds PC and nPC with MIPS branch-delay-slot semantics, selects the next nPC (sequential, branch, jump, exception), and supports stalls. A redirect that arrives during a stall is buffered rather than lost. Sits at the front of IF; `pc` drives the instruction ROM address and the IF/ID register.

Parameters:
ADDR_WIDTH, 32, width of pc/npc and all targets
INSTR_BYTES, 4, fetch increment; power of two
RESET_PC, 0, pc value on reset; npc resets to RESET_PC+INSTR_BYTES
EXC_VECTOR, 32'h80, exception redirect address

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hold pc/npc this cycle
branch_taken  in  1  conditional branch resolved taken
branch_target  in  ADDR_WIDTH  branch destination
jump  in  1  unconditional jump/jal/jr
jump_target  in  ADDR_WIDTH  jump destination
exc_req  in  1  exception request; ignores stall
pc  out  ADDR_WIDTH  current fetch address
npc  out  ADDR_WIDTH  next fetch address
pc_plus8  out  ADDR_WIDTH  link value = pc+2*INSTR_BYTES, combinational
fetch_valid  out  1  pc holds a fetchable instruction
redirect_pending  out  1  buffered redirect awaiting stall release
flush_if  out  1  registered one-cycle pulse; IF/ID must squash
align_err  out  1  registered one-cycle pulse; selected target misaligned

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, npc=RESET_PC+INSTR_BYTES, fetch_valid=0, redirect_pending=0, pend_target=0, flush_if=0, align_err=0, state=WARMUP.
- FSM states:
  - WARMUP: first clock edge after reset release goes to RUN and sets fetch_valid=1. pc/npc hold on this edge.
  - RUN: normal operation. stall with a redirect goes to HOLD.
  - HOLD: redirect buffered. The first edge with stall=0 goes to RUN.
- Target selection, priority exc_req > jump > branch_taken > sequential:
  - sel = jump ? jump_target : branch_taken ? branch_target : npc+INSTR_BYTES.
- RUN, stall=0 edge (delay slot preserved): pc<=npc; npc<=sel.
- RUN, stall=1 edge:
  - pc and npc hold.
  - If jump or branch_taken is asserted: pend_target<=sel, redirect_pending<=1, go to HOLD.
- HOLD, stall=1 edge:
  - A new jump/branch overwrites pend_target (latest wins).
  - Otherwise hold.
- HOLD, stall=0 edge:
  - pc<=npc.
  - npc<=(jump|branch_taken) ? sel : pend_target.
  - redirect_pending<=0, go to RUN.
- exc_req edge, any state except WARMUP, regardless of stall:
  - pc<=EXC_VECTOR, npc<=EXC_VECTOR+INSTR_BYTES. No delay slot.
  - Clear redirect_pending, go to RUN, flush_if<=1 for exactly one cycle.
- exc_req in WARMUP is ignored.
- Arithmetic is modulo 2^ADDR_WIDTH; pc/npc wrap from all-ones.
- Alignment:
  - The low log2(INSTR_BYTES) bits of a selected branch/jump target are forced to 0 before use.
  - If any forced bit was 1, align_err pulses for one cycle on the same edge the target is captured (into npc or pend_target).
- pc_plus8 follows pc combinationally. There are no other combinational input-to-output paths.
- Reset asserted mid-stall or with redirect_pending=1 discards the buffered target.

Test Plan:
- Reset release, no stall, defaults: first edge → pc=0, fetch_valid=1; next edges → pc=0,4,8,12; npc always pc+4; pc_plus8=pc+8.
- At pc=8,npc=12, branch_taken=1, target=0x40 for one cycle → pc=12 (delay slot), then pc=0x40, 0x44.
- stall=1 for 3 cycles at pc=16; jump=1, target=0x100 in stall cycle 1 → pc holds 16, redirect_pending=1; after release pc=20 then 0x100, redirect_pending=0.
- Under stall, branch target 0x200 then jump target 0x300 → pend_target=0x300; same-cycle branch_taken+jump (0x10/0x20) → npc=0x20.
- exc_req=1 while stall=1 and redirect_pending=1 → next edge pc=0x80, npc=0x84, flush_if high one cycle, redirect_pending=0.
- jump_target=0x103 → npc=0x100, align_err single pulse.
- ADDR_WIDTH=8, pc=0xFC → pc sequence 0xFC,0x00,0x04.
- Async reset asserted mid-cycle → outputs return to reset values immediately.

Source files
------------

// File: rtl/pc_npc_fetch_unit.sv
// PC/nPC fetch pair with MIPS delay-slot semantics, stall handling and a
// one-entry redirect buffer that keeps a branch/jump seen during a stall.
module pc_npc_fetch_unit #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_BYTES = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0]  EXC_VECTOR  = 'h80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  exc_req,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] npc,
  output logic [ADDR_WIDTH-1:0] pc_plus8,
  output logic                  fetch_valid,
  output logic                  redirect_pending,
  output logic                  flush_if,
  output logic                  align_err,
  output logic [1:0]            state_dbg
);

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINK_OFS   = ADDR_WIDTH'(2 * INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] npc_q, npc_d;
  logic [ADDR_WIDTH-1:0] pend_q, pend_d;
  logic                  rp_q, rp_d;
  logic                  fv_q, fv_d;
  logic                  flush_q, flush_d;
  logic                  aerr_q, aerr_d;

  logic                  redirect;
  logic                  tgt_mis;
  logic [ADDR_WIDTH-1:0] sel;

  // Misalignment is judged on the target that wins priority, not on both.
  assign redirect = jump | branch_taken;
  assign tgt_mis  = jump ? (|(jump_target & ALIGN_MASK))
                         : (|(branch_target & ALIGN_MASK));
  assign sel      = jump         ? (jump_target & ~ALIGN_MASK)
                  : branch_taken ? (branch_target & ~ALIGN_MASK)
                  : (npc_q + STEP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    pend_d  = pend_q;
    rp_d    = rp_q;
    fv_d    = fv_q;
    flush_d = 1'b0;
    aerr_d  = 1'b0;
    if (exc_req && state_q != ST_WARMUP) begin
      // Exceptions bypass the delay slot and drop any buffered redirect.
      pc_d    = EXC_VECTOR;
      npc_d   = EXC_VECTOR + STEP;
      rp_d    = 1'b0;
      flush_d = 1'b1;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          state_d = ST_RUN;
          fv_d    = 1'b1;
        end
        ST_RUN: begin
          if (!stall) begin
            pc_d   = npc_q;
            npc_d  = sel;
            aerr_d = redirect & tgt_mis;
          end else if (redirect) begin
            pend_d  = sel;
            rp_d    = 1'b1;
            aerr_d  = tgt_mis;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (stall) begin
            if (redirect) begin
              pend_d = sel;
              aerr_d = tgt_mis;
            end
          end else begin
            // A fresh redirect on the release edge supersedes the buffered one.
            pc_d    = npc_q;
            npc_d   = redirect ? sel : pend_q;
            aerr_d  = redirect & tgt_mis;
            rp_d    = 1'b0;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WARMUP;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + STEP;
      pend_q  <= '0;
      rp_q    <= 1'b0;
      fv_q    <= 1'b0;
      flush_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      pend_q  <= pend_d;
      rp_q    <= rp_d;
      fv_q    <= fv_d;
      flush_q <= flush_d;
      aerr_q  <= aerr_d;
    end
  end

  assign pc               = pc_q;
  assign npc              = npc_q;
  assign pc_plus8         = pc_q + LINK_OFS;
  assign fetch_valid      = fv_q;
  assign redirect_pending = rp_q;
  assign flush_if         = flush_q;
  assign align_err        = aerr_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_pc_npc_fetch_unit.sv
// Bench for pc_npc_fetch_unit: vector table through an expected-record queue,
// plus reset/warmup sequences and an 8-bit wrap instance.
module tb_pc_npc_fetch_unit;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        exc;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_fv;
    logic        e_rp;
    logic        e_flush;
    logic        e_aerr;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        exc_req = 1'b0;
  logic [31:0] pc, npc, pc_plus8;
  logic        fetch_valid, redirect_pending, flush_if, align_err;
  logic [1:0]  state_dbg;

  pc_npc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc_req(exc_req),
    .pc(pc), .npc(npc), .pc_plus8(pc_plus8), .fetch_valid(fetch_valid),
    .redirect_pending(redirect_pending), .flush_if(flush_if),
    .align_err(align_err), .state_dbg(state_dbg)
  );

  logic       reset8 = 1'b1;
  logic       z1 = 1'b0;
  logic [7:0] z8 = '0;
  logic [7:0] pc8, npc8, pc_plus8_8;
  logic       fv8, rp8, flush8, aerr8;
  logic [1:0] state8;

  pc_npc_fetch_unit #(.ADDR_WIDTH(8), .INSTR_BYTES(4), .RESET_PC(8'hFC),
                      .EXC_VECTOR(8'h80)) dut8 (
    .clk(clk), .reset(reset8), .stall(z1),
    .branch_taken(z1), .branch_target(z8),
    .jump(z1), .jump_target(z8), .exc_req(z1),
    .pc(pc8), .npc(npc8), .pc_plus8(pc_plus8_8), .fetch_valid(fv8),
    .redirect_pending(rp8), .flush_if(flush8),
    .align_err(aerr8), .state_dbg(state8)
  );

  // ---------------- scoreboard ----------------
  int   checks = 0;
  int   failures = 0;
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic e,
                              input logic [31:0] epc, input logic [31:0] enpc,
                              input logic efv, input logic erp, input logic efl,
                              input logic eae);
    vec_t v;
    v.stall = s; v.br = b; v.bt = bt; v.j = j; v.jt = jt; v.exc = e;
    v.e_pc = epc; v.e_npc = enpc; v.e_fv = efv; v.e_rp = erp;
    v.e_flush = efl; v.e_aerr = eae;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge: drive, queue the expectation, compare just after the edge.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    stall = v.stall; branch_taken = v.br; branch_target = v.bt;
    jump = v.j; jump_target = v.jt; exc_req = v.exc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".pc"}, pc, e.e_pc);
    chk({tag, ".npc"}, npc, e.e_npc);
    chk({tag, ".pc_plus8"}, pc_plus8, e.e_pc + 32'd8);
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e.e_fv});
    chk({tag, ".redirect_pending"}, {31'd0, redirect_pending}, {31'd0, e.e_rp});
    chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, e.e_flush});
    chk({tag, ".align_err"}, {31'd0, align_err}, {31'd0, e.e_aerr});
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pc"}, pc, 32'h0);
    chk({tag, ".npc"}, npc, 32'h4);
    chk({tag, ".pc_plus8"}, pc_plus8, 32'h8);
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, 32'd0);
    chk({tag, ".redirect_pending"}, {31'd0, redirect_pending}, 32'd0);
    chk({tag, ".flush_if"}, {31'd0, flush_if}, 32'd0);
    chk({tag, ".align_err"}, {31'd0, align_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  vec_t vecs[27];

  initial begin
    //            stall br bt        j  jt        exc pc        npc       fv rp fl ae
    vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h4,   1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h4,   32'h8,   1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h8,   32'hC,   1, 0, 0, 0);
    vecs[3]  = mk(0, 1, 32'h40,  0, 32'h0,   0, 32'hC,   32'h40,  1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h40,  32'h44,  1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h44,  32'h48,  1, 0, 0, 0);
    vecs[6]  = mk(1, 0, 32'h0,   1, 32'h100, 0, 32'h44,  32'h48,  1, 1, 0, 0);
    vecs[7]  = mk(1, 0, 32'h0,   0, 32'h0,   0, 32'h44,  32'h48,  1, 1, 0, 0);
    vecs[8]  = mk(1, 0, 32'h0,   0, 32'h0,   0, 32'h44,  32'h48,  1, 1, 0, 0);
    vecs[9]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h48,  32'h100, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h104, 1, 0, 0, 0);
    vecs[11] = mk(1, 1, 32'h200, 0, 32'h0,   0, 32'h100, 32'h104, 1, 1, 0, 0);
    vecs[12] = mk(1, 0, 32'h0,   1, 32'h300, 0, 32'h100, 32'h104, 1, 1, 0, 0);
    vecs[13] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 32'h300, 1, 0, 0, 0);
    vecs[14] = mk(0, 1, 32'h10,  1, 32'h20,  0, 32'h300, 32'h20,  1, 0, 0, 0);
    vecs[15] = mk(1, 0, 32'h0,   1, 32'h400, 0, 32'h300, 32'h20,  1, 1, 0, 0);
    vecs[16] = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h80,  32'h84,  1, 0, 1, 0);
    vecs[17] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h84,  32'h88,  1, 0, 0, 0);
    vecs[18] = mk(0, 0, 32'h0,   1, 32'h103, 0, 32'h88,  32'h100, 1, 0, 0, 1);
    vecs[19] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h104, 1, 0, 0, 0);
    vecs[20] = mk(1, 1, 32'h202, 0, 32'h0,   0, 32'h100, 32'h104, 1, 1, 0, 1);
    vecs[21] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 32'h200, 1, 0, 0, 0);
    vecs[22] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  32'h84,  1, 0, 1, 0);
    vecs[23] = mk(1, 0, 32'h0,   0, 32'h0,   0, 32'h80,  32'h84,  1, 0, 0, 0);
    vecs[24] = mk(1, 0, 32'h0,   1, 32'h500, 0, 32'h80,  32'h84,  1, 1, 0, 0);
    vecs[25] = mk(0, 1, 32'h600, 0, 32'h0,   0, 32'h84,  32'h600, 1, 0, 0, 0);
    vecs[26] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h600, 32'h604, 1, 0, 0, 0);

    #1;
    reset = 1'b0;
    reset8 = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 27; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Buffer a redirect, then pull reset in the middle of a cycle.
    run_vec(mk(1, 0, 32'h0, 1, 32'h700, 0, 32'h600, 32'h604, 1, 1, 0, 0), "pre_rst");
    jump = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    stall = 1'b0;
    reset = 1'b1;

    // Exception on the warmup edge is ignored; the discarded target never shows up.
    run_vec(mk(0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h4, 1, 0, 0, 0), "warm_exc");
    run_vec(mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h4, 32'h8, 1, 0, 0, 0), "post_warm");
    exc_req = 1'b0;

    // 8-bit instance: wrap from 0xFC.
    reset8 = 1'b1;
    @(posedge clk);
    #1;
    chk("w8.warm.pc", {24'd0, pc8}, 32'hFC);
    chk("w8.warm.fv", {31'd0, fv8}, 32'd1);
    @(posedge clk);
    #1;
    chk("w8.e1.pc", {24'd0, pc8}, 32'h00);
    chk("w8.e1.npc", {24'd0, npc8}, 32'h04);
    chk("w8.e1.pc_plus8", {24'd0, pc_plus8_8}, 32'h08);
    @(posedge clk);
    #1;
    chk("w8.e2.pc", {24'd0, pc8}, 32'h04);
    chk("w8.e2.npc", {24'd0, npc8}, 32'h08);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_q_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
